// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: quadrant encodings and phase constants (degrees x 10^4),
// used by both the pre-rotation stage and the output-side quadrant restorer.
package cordic_pkg;

  typedef logic [1:0] quadrant_t;

  localparam quadrant_t Q1 = 2'b00;
  localparam quadrant_t Q2 = 2'b01;
  localparam quadrant_t Q3 = 2'b11;
  localparam quadrant_t Q4 = 2'b10;

  localparam logic signed [21:0] PHASE_P90  = 22'sd900000;
  localparam logic signed [21:0] PHASE_180  = 22'sd1800000;
  localparam logic signed [21:0] PHASE_N90  = -22'sd900000;

  // Q2/Q3 were folded by +-180 deg upstream, so their results come back negated.
  function automatic logic quad_negates(input quadrant_t q);
    return q[0];
  endfunction

endpackage

// File: rtl/cordic_quad_fifo.sv
// In-order quadrant-code FIFO with occupancy level and sticky overflow/underflow flags.
// An underflowing pop returns Q1 so the restorer passes data through unchanged.
module cordic_quad_fifo
  import cordic_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  quadrant_t     push_data,
  input  logic          pop,
  output quadrant_t     pop_data,
  output logic [AW:0]   level,
  output logic          err_ovf,
  output logic          err_unf
);

  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  quadrant_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            empty;
  logic            full;
  logic            do_pop;
  logic            do_push;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign pop_data = do_pop ? mem[rd_ptr] : Q1;

  // NOTE: storage has no reset; the pointers and level alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push && !do_push) err_ovf <= 1'b1;
      if (pop && empty)     err_unf <= 1'b1;
    end
  end

endmodule

// File: rtl/cordic_post.sv
// CORDIC output quadrant restorer: buffers quadrant codes across the rotation core and
// re-signs cos/sin on delivery. Define CORDIC_POST_SAT_EN to saturate negation of the minimum value.
module cordic_post
  import cordic_pkg::*;
#(
  parameter int DATA_W     = 18,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [1:0]                         quad_in,
  input  logic                               quad_valid,
  input  logic signed [DATA_W-1:0]           cos_in,
  input  logic signed [DATA_W-1:0]           sin_in,
  input  logic                               core_valid,
  output logic signed [DATA_W-1:0]           cos_out,
  output logic signed [DATA_W-1:0]           sin_out,
  output logic                               out_valid,
  output logic                               err_ovf,
  output logic                               err_unf,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level
);

`ifdef CORDIC_POST_SAT_EN
  localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
`endif

  quadrant_t pop_quad;
  logic      negate;

  cordic_quad_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (quad_valid),
    .push_data (quad_in),
    .pop       (core_valid),
    .pop_data  (pop_quad),
    .level     (fifo_level),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf)
  );

  assign negate = quad_negates(pop_quad);

  function automatic logic signed [DATA_W-1:0] restore(
    input logic signed [DATA_W-1:0] v,
    input logic                     neg
  );
    logic signed [DATA_W-1:0] r;
    r = neg ? -v : v;
`ifdef CORDIC_POST_SAT_EN
    if (neg && v == MIN_VAL) r = MAX_VAL;
`endif
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cos_out   <= '0;
      sin_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= core_valid;
      if (core_valid) begin
        cos_out <= restore(cos_in, negate);
        sin_out <= restore(sin_in, negate);
      end
    end
  end

endmodule

// File: tb/tb_cordic_post.sv
// Self-checking bench for cordic_post: directed test-plan steps followed by random traffic,
// compared against a queue-based reference model of the quadrant restorer.
module tb_cordic_post;

  localparam int DW    = 18;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int MINV  = -(1 << (DW - 1));
  localparam int MAXV  = (1 << (DW - 1)) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [1:0]           quad_in = 2'b00;
  logic                 quad_valid = 1'b0;
  logic signed [DW-1:0] cos_in = '0;
  logic signed [DW-1:0] sin_in = '0;
  logic                 core_valid = 1'b0;
  logic signed [DW-1:0] cos_out;
  logic signed [DW-1:0] sin_out;
  logic                 out_valid;
  logic                 err_ovf;
  logic                 err_unf;
  logic [LW-1:0]        fifo_level;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [1:0] mq[$];
  bit         m_ovf;
  bit         m_unf;
  bit         m_valid;
  int         m_cos;
  int         m_sin;

  cordic_post #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .quad_in    (quad_in),
    .quad_valid (quad_valid),
    .cos_in     (cos_in),
    .sin_in     (sin_in),
    .core_valid (core_valid),
    .cos_out    (cos_out),
    .sin_out    (sin_out),
    .out_valid  (out_valid),
    .err_ovf    (err_ovf),
    .err_unf    (err_unf),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Q2 and Q3 negate; negating the most negative value saturates or wraps.
  function automatic int apply(input logic [1:0] q, input int v);
    int r;
    r = v;
    if (q == 2'b01 || q == 2'b11) begin
      r = -v;
      if (r > MAXV) begin
`ifdef CORDIC_POST_SAT_EN
        r = MAXV;
`else
        r = MINV;
`endif
      end
    end
    return r;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check({tag, ".cos"}, $signed(cos_out), m_cos);
      check({tag, ".sin"}, $signed(sin_out), m_sin);
    end
    check({tag, ".level"}, 32'(fifo_level), mq.size());
    check({tag, ".ovf"}, 32'(err_ovf), 32'(m_ovf));
    check({tag, ".unf"}, 32'(err_unf), 32'(m_unf));
  endtask

  // One clock of stimulus, driven just after a falling edge and checked on the next falling edge.
  task automatic step(input string tag, input bit push, input logic [1:0] q,
                      input bit pop, input int c, input int s);
    logic [1:0] code;
    logic [31:0] cw;
    logic [31:0] sw;
    cw = c;
    sw = s;
    quad_valid = push;
    quad_in    = q;
    core_valid = pop;
    cos_in     = cw[DW-1:0];
    sin_in     = sw[DW-1:0];
    m_valid = pop;
    if (pop) begin
      if (mq.size() == 0) begin
        m_unf = 1'b1;
        code  = 2'b00;
      end else begin
        code = mq.pop_front();
      end
      m_cos = apply(code, c);
      m_sin = apply(code, s);
    end
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(q);
      else m_ovf = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    quad_valid = 1'b0;
    core_valid = 1'b0;
    check_all(tag);
  endtask

  // Reset held for one edge with stimulus asserted, which must be ignored.
  task automatic do_reset(input string tag);
    rst        = 1'b1;
    quad_valid = 1'b1;
    quad_in    = 2'b11;
    core_valid = 1'b1;
    cos_in     = 18'sd1234;
    sin_in     = 18'sd4321;
    @(posedge clk);
    @(negedge clk);
    rst        = 1'b0;
    quad_valid = 1'b0;
    core_valid = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_valid = 1'b0;
    check({tag, ".valid"}, 32'(out_valid), 0);
    check({tag, ".cos"}, $signed(cos_out), 0);
    check({tag, ".sin"}, $signed(sin_out), 0);
    check({tag, ".level"}, 32'(fifo_level), 0);
    check({tag, ".ovf"}, 32'(err_ovf), 0);
    check({tag, ".unf"}, 32'(err_unf), 0);
  endtask

  initial begin
    logic [1:0] qs [4];
    int thr;
    qs[0] = 2'b00; qs[1] = 2'b01; qs[2] = 2'b11; qs[3] = 2'b10;

    do_reset("reset0");

    // Pass-through and negation for each quadrant
    for (int i = 0; i < 4; i++) step("t1.push", 1, qs[i], 0, 0, 0);
    for (int i = 0; i < 4; i++) step("t1.pop", 0, 2'b00, 1, 1000, -500);
    step("t1.idle", 0, 2'b00, 0, 0, 0);

    // Fill to 16 with alternating Q1/Q2, then a dropped 17th push
    for (int i = 0; i < DEPTH; i++) step("t2.push", 1, (i % 2 == 0) ? 2'b00 : 2'b01, 0, 0, 0);
    step("t3.ovf", 1, 2'b11, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step("t2.pop", 0, 2'b00, 1, 300 + i, -40 - i);

    // Underflow, then simultaneous push/pop on empty FIFO
    step("t4.unf", 0, 2'b00, 1, -7, 9);
    step("t4.pushpop", 1, 2'b11, 1, 55, -66);
    step("t4.drain", 0, 2'b00, 1, 77, -88);

    // Full FIFO with simultaneous push/pop keeps level and raises no overflow
    do_reset("reset1");
    for (int i = 0; i < DEPTH; i++) step("t3.fill", 1, qs[i % 4], 0, 0, 0);
    step("t3.fullpp", 1, 2'b01, 1, 11, 22);
    for (int i = 0; i < DEPTH; i++) step("t3.drain", 0, 2'b00, 1, i, -i);

    // Most negative value through a negating quadrant
    step("t5.push", 1, 2'b11, 0, 0, 0);
    step("t5.sat", 0, 2'b00, 1, MINV, MINV);

    // Reset with codes pending, then pop flags underflow
    for (int i = 0; i < 5; i++) step("t6.push", 1, 2'b01, 0, 0, 0);
    do_reset("t6.rst");
    step("t6.unf", 0, 2'b00, 1, 123, -321);

    // Random traffic with drifting push/pop balance to visit full and empty
    do_reset("reset2");
    for (int i = 0; i < 400; i++) begin
      thr = ((i / 100) % 2 == 0) ? 7 : 3;
      step("rand", $urandom_range(0, 9) < thr, 2'($urandom_range(0, 3)),
           $urandom_range(0, 9) >= thr,
           int'($urandom_range(0, (1 << DW) - 1)) + MINV,
           int'($urandom_range(0, (1 << DW) - 1)) + MINV);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_post.md
# cordic_post

Output-side quadrant restorer for the CORDIC cosine/sine path. Accepts the quadrant code issued at the pre-rotation stage, buffers it in a small in-order FIFO across the variable-latency CORDIC rotation core, and restores the sign of the core's cos/sin results when the core delivers them. The output is a registered, valid-qualified cos/sin pair for the full (-180°, 180°] phase range.

## Interface
- `DATA_W`, default 18: width of the signed cos/sin samples, input and output.
- `FIFO_DEPTH`, default 16: quadrant FIFO depth; must be a power of 2, at least 2.
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset; synchronous, active-high.
- `quad_in`, input, 2: quadrant code from the pre-rotation stage.
- `quad_valid`, input, 1: pushes `quad_in` into the FIFO, one push per phase sample entering the core.
- `cos_in`, input, DATA_W: signed core cosine, scaled to phase_pre.
- `sin_in`, input, DATA_W: signed core sine, scaled to phase_pre.
- `core_valid`, input, 1: core result valid; pops one FIFO entry.
- `cos_out`, output, DATA_W: corrected cosine.
- `sin_out`, output, DATA_W: corrected sine.
- `out_valid`, output, 1: `cos_out`/`sin_out` are valid.
- `err_ovf`, output, 1: sticky; a push was dropped because the FIFO was full.
- `err_unf`, output, 1: sticky; a pop was attempted while the FIFO was empty.
- `fifo_level`, output, log2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Quadrant codes: Q1 = 2'b00, Q2 = 2'b01, Q3 = 2'b11, Q4 = 2'b10.
  - Q2 and Q3 were folded by ±180° upstream, so both results are negated.
  - Q1 and Q4 pass through unchanged.
  - Negate when `quad[0]` is 1.
- FIFO pushes on `quad_valid` and pops on `core_valid`. Strictly in order; no bypass.
- Correction is applied with the popped code: `cos_out = ±cos_in`, `sin_out = ±sin_in`.
- Push and pop in the same cycle:
  - FIFO non-empty and not full: both succeed; level unchanged.
  - FIFO full: both succeed; level unchanged; `err_ovf` is not set.
  - FIFO empty: the pop is an underflow. `err_unf` is set, the result uses Q1 (pass-through), and the push is stored, so the level becomes 1.
- Push when full with no pop: the entry is dropped and `err_ovf` is set.
- Pop when empty with no push: `err_unf` is set, the result is emitted using Q1, and `out_valid` still asserts.
- Error flags clear only on `rst`.
- Arithmetic: negation is two's complement at DATA_W. The only overflow case is negating -2^(DATA_W-1); it is handled per Configuration.

## Timing
- Latency: `core_valid` in cycle N gives `out_valid` and the data in cycle N+1. Fully pipelined, one result per cycle, no stall input.
- A quadrant push must occur at least 1 cycle before its matching pop.
- `fifo_level` reflects pushes and pops on the cycle after the edge.
- Reset: on any edge with `rst` high, the following all go to 0 on the next cycle:
  - `cos_out`, `sin_out`, `out_valid`
  - `err_ovf`, `err_unf`
  - `fifo_level`, and the read and write pointers.
- Reset mid-operation discards in-flight quadrant codes. Inputs asserted in the reset cycle are ignored.
- `out_valid` is low in every cycle that is not one cycle after an accepted `core_valid`.

## Configuration
- `CORDIC_POST_SAT_EN` defined: negating -2^(DATA_W-1) yields +2^(DATA_W-1)-1.
- `CORDIC_POST_SAT_EN` undefined: plain two's-complement wrap, so -2^(DATA_W-1) stays -2^(DATA_W-1). No saturation logic is instantiated.

## Structure
- Shared package `cordic_pkg` holds:
  - the quadrant encodings Q1..Q4 as localparams and a 2-bit `quadrant_t` typedef;
  - the phase constants 90° = 900000, 180° = 1800000, -90° = -900000 (22-bit signed, degrees×10^4).
  - The pre-rotation stage imports the same package.
- One sub-module, `cordic_quad_fifo`: synchronous FIFO, 2-bit wide, FIFO_DEPTH deep, with level, full/empty and the ovf/unf rules above.
- Sign correction, optional saturation and the output register live in `cordic_post`.

## Test plan
1. Passthrough and negation: push Q1, Q2, Q3, Q4, then core results cos=1000, sin=-500 for each. Required outputs, one cycle later each: (1000, -500), (-1000, 500), (-1000, 500), (1000, -500).
2. Back-to-back: 16 pushes with alternating Q1/Q2, then 16 consecutive pops. Required: 16 consecutive `out_valid` cycles with signs alternating, and `fifo_level` goes 16 → 0.
3. Overflow: a 17th push with no pop. Required: `err_ovf`=1, `fifo_level`=16, and the following 16 pops return the first 16 codes.
4. Underflow: `core_valid` with an empty FIFO and cos_in=-7. Required: `err_unf`=1 and `cos_out`=-7. Same-cycle push and pop on an empty FIFO gives `fifo_level`=1.
5. Saturation: Q3 with cos_in=-131072 at DATA_W=18. Required: `cos_out`=131071 with the macro defined, -131072 without it.
6. Reset mid-stream: 5 codes pending, assert `rst` for 1 cycle. Required: all outputs 0 and `fifo_level`=0; a subsequent pop flags `err_unf`.
